// File: rtl/data_ram_resp_pkg.sv
// Shared constants, request encoding and byte-merge helper for the data SRAM responder.
package data_ram_resp_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned LANES   = 4;
   localparam int unsigned LED_W   = 16;
   localparam int unsigned OFF_W   = 16;

   // addr[31:16] value that selects the MMIO window
   localparam logic [OFF_W-1:0] MMIO_HI = 16'hbfaf;

   // MMIO register offsets within the window, addr[15:0]
   localparam logic [OFF_W-1:0] OFF_TIMER   = 16'he000;
   localparam logic [OFF_W-1:0] OFF_LED     = 16'hf000;
   localparam logic [OFF_W-1:0] OFF_SCRATCH = 16'hf010;

   // All-zero byte enables mean a read
   localparam logic [LANES-1:0] WEN_READ = 4'b0000;

   typedef enum logic [1:0] {
      REQ_IDLE  = 2'd0,
      REQ_READ  = 2'd1,
      REQ_WRITE = 2'd2
   } req_e;

   // Source of the response word on the next cycle
   typedef enum logic {
      SRC_RAM  = 1'b0,
      SRC_MMIO = 1'b1
   } src_e;

   // Classify a request from its strobe and byte enables
   function automatic req_e req_decode(input logic en, input logic [LANES-1:0] wen);
      req_e r;
      if (!en) begin
         r = REQ_IDLE;
      end else if (wen == WEN_READ) begin
         r = REQ_READ;
      end else begin
         r = REQ_WRITE;
      end
      return r;
   endfunction

   // Replace each byte lane whose enable is set; with no enables the old word is returned
   function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] old_word,
                                                     input logic [WORD_W-1:0] new_word,
                                                     input logic [LANES-1:0]  be);
      logic [WORD_W-1:0] r;
      for (int i = 0; i < int'(LANES); i++) begin
         r[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/data_ram_resp_byte_ram.sv
// Single-port word RAM with byte write enables, registered write-first read, no reset.
module data_ram_resp_byte_ram #(
   parameter int unsigned RAM_AW = 12
) (
   input  logic                clk,
   input  logic                en,
   input  logic [3:0]          we,
   input  logic [RAM_AW-1:0]   addr,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata
);
   import data_ram_resp_pkg::*;

   localparam int unsigned DEPTH = 2 ** RAM_AW;

   logic [WORD_W-1:0] mem [DEPTH];

   // Byte-lane write and write-first registered read; contents survive reset
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (we[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         rdata <= byte_merge(mem[addr], wdata, we);
      end
   end

endmodule

// File: rtl/data_ram_resp.sv
// Responder for the CPU data SRAM bus: word RAM plus LED/TIMER/SCRATCH MMIO window.
module data_ram_resp #(
   parameter int unsigned RAM_AW  = 12,
   parameter logic [15:0] MMIO_HI = data_ram_resp_pkg::MMIO_HI
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   output logic [31:0] timer
);
   import data_ram_resp_pkg::*;

   req_e               req;
   logic               is_mmio;
   logic [OFF_W-1:0]   offset;
   logic               ram_en;
   logic [RAM_AW-1:0]  ram_addr;
   logic [WORD_W-1:0]  ram_rdata;

   logic [WORD_W-1:0]  timer_q,   timer_d;
   logic [LED_W-1:0]   led_q,     led_d;
   logic [WORD_W-1:0]  scratch_q, scratch_d;
   logic [WORD_W-1:0]  mmio_rd_q, mmio_rd_d;
   src_e               src_q,     src_d;

   logic [WORD_W-1:0]  timer_merged;
   logic [WORD_W-1:0]  led_merged;
   logic [WORD_W-1:0]  scratch_merged;

   // Byte offset within a word is irrelevant to a word-addressed target
   logic [1:0] unused_addr_lsb;
   assign unused_addr_lsb = data_sram_addr[1:0];

   // Request classification and address decode
   assign req      = req_decode(data_sram_en, data_sram_wen);
   assign is_mmio  = (data_sram_addr[31:16] == MMIO_HI);
   assign offset   = data_sram_addr[OFF_W-1:0];
   assign ram_addr = data_sram_addr[RAM_AW+1:2];

   // A request sampled while reset is held must not touch the RAM either
   assign ram_en = (req != REQ_IDLE) && !is_mmio && resetn;

   data_ram_resp_byte_ram #(
      .RAM_AW (RAM_AW)
   ) u_byte_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (data_sram_wen),
      .addr  (ram_addr),
      .wdata (data_sram_wdata),
      .rdata (ram_rdata)
   );

   // Next state of the MMIO registers, the registered MMIO read word and the mux select
   always_comb begin
      timer_merged   = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
      led_merged     = byte_merge({16'h0000, led_q}, data_sram_wdata, data_sram_wen);
      scratch_merged = byte_merge(scratch_q, data_sram_wdata, data_sram_wen);

      timer_d   = timer_q + 32'd1;
      led_d     = led_q;
      scratch_d = scratch_q;
      mmio_rd_d = mmio_rd_q;
      src_d     = src_q;

      if (req != REQ_IDLE) begin
         if (is_mmio) begin
            src_d = SRC_MMIO;
            // With no byte enables the merged word equals the old one, so reads share this path
            unique case (offset)
               OFF_TIMER: begin
                  mmio_rd_d = timer_merged;
                  if (req == REQ_WRITE) begin
                     timer_d = timer_merged;
                  end
               end
               OFF_LED: begin
                  led_d     = LED_W'(led_merged);
                  mmio_rd_d = {16'h0000, LED_W'(led_merged)};
               end
               OFF_SCRATCH: begin
                  scratch_d = scratch_merged;
                  mmio_rd_d = scratch_merged;
               end
               default: begin
                  mmio_rd_d = '0;
               end
            endcase
         end else begin
            src_d = SRC_RAM;
         end
      end
   end

   // MMIO state and response select; reset selects the zeroed MMIO word so rdata reads 0
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer_q   <= '0;
         led_q     <= '0;
         scratch_q <= '0;
         mmio_rd_q <= '0;
         src_q     <= SRC_MMIO;
      end else begin
         timer_q   <= timer_d;
         led_q     <= led_d;
         scratch_q <= scratch_d;
         mmio_rd_q <= mmio_rd_d;
         src_q     <= src_d;
      end
   end

   assign data_sram_rdata = (src_q == SRC_MMIO) ? mmio_rd_q : ram_rdata;
   assign led             = led_q;
   assign timer           = timer_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed self-checking bench for data_ram_resp.
module tb_data_ram_resp;

   localparam int unsigned RAM_AW = 12;

   logic        clk;
   logic        resetn;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [15:0] led;
   logic [31:0] timer;

   int n_checks = 0;
   int n_pass   = 0;

   data_ram_resp #(
      .RAM_AW  (RAM_AW),
      .MMIO_HI (16'hbfaf)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .led             (led),
      .timer           (timer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // One request across one edge, then back to idle; returns 1 time unit after the edge
   task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      en    = 1'b1;
      wen   = w;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
      en    = 1'b0;
      wen   = 4'h0;
      addr  = 32'h0;
      wdata = 32'h0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      en     = 1'b0;
      wen    = 4'h0;
      addr   = 32'h0;
      wdata  = 32'h0;
      resetn = 1'b1;
      #1 resetn = 1'b0;

      // Reset then idle
      idle(3);
      check("rst_rdata", rdata, 32'h0);
      check("rst_led", {16'h0, led}, 32'h0);
      check("rst_timer", timer, 32'h0);
      resetn = 1'b1;
      check("timer_0", timer, 32'd0);
      idle(1);
      check("timer_1", timer, 32'd1);
      idle(1);
      check("timer_2", timer, 32'd2);
      idle(1);
      check("timer_3", timer, 32'd3);

      // Word write, write-first response, read back
      req(4'hf, 32'h0000_0010, 32'hdead_beef);
      check("wr_word", rdata, 32'hdead_beef);
      req(4'h0, 32'h0000_0010, 32'h0);
      check("rd_word", rdata, 32'hdead_beef);

      // Idle holds the last response
      idle(2);
      check("idle_hold", rdata, 32'hdead_beef);

      // Byte lanes 0 and 2
      req(4'b0101, 32'h0000_0010, 32'h1122_3344);
      check("wr_bytes", rdata, 32'hde22_be44);
      req(4'h0, 32'h0000_0010, 32'h0);
      check("rd_bytes", rdata, 32'hde22_be44);

      // A second word kept for the reset retention check
      req(4'hf, 32'h0000_0020, 32'hcafe_f00d);
      check("wr_w20", rdata, 32'hcafe_f00d);

      // Aliasing: one RAM depth above 0x10 lands on the same word
      req(4'hf, 32'h0000_0010 + (32'd4 << RAM_AW), 32'h5a5a_5a5a);
      check("wr_alias", rdata, 32'h5a5a_5a5a);
      req(4'h0, 32'h0000_0010, 32'h0);
      check("rd_alias", rdata, 32'h5a5a_5a5a);
      req(4'h0, 32'h0000_0020, 32'h0);
      check("rd_w20", rdata, 32'hcafe_f00d);

      // LED
      req(4'hf, 32'hbfaf_f000, 32'hffff_1234);
      check("wr_led_rdata", rdata, 32'h0000_1234);
      check("wr_led_out", {16'h0, led}, 32'h0000_1234);
      req(4'h0, 32'hbfaf_f000, 32'h0);
      check("rd_led", rdata, 32'h0000_1234);
      req(4'b1110, 32'hbfaf_f000, 32'h5500_ab00);
      check("wr_led_byte", rdata, 32'h0000_ab34);
      check("led_byte_out", {16'h0, led}, 32'h0000_ab34);

      // SCRATCH
      req(4'hf, 32'hbfaf_f010, 32'h1234_5678);
      check("wr_scratch", rdata, 32'h1234_5678);
      req(4'b1000, 32'hbfaf_f010, 32'h9900_0000);
      check("wr_scratch_b3", rdata, 32'h9934_5678);
      req(4'h0, 32'hbfaf_f010, 32'h0);
      check("rd_scratch", rdata, 32'h9934_5678);

      // TIMER load, pre-increment reads and wrap
      req(4'hf, 32'hbfaf_e000, 32'hffff_fffe);
      check("wr_timer_rdata", rdata, 32'hffff_fffe);
      check("wr_timer_out", timer, 32'hffff_fffe);
      req(4'h0, 32'hbfaf_e000, 32'h0);
      check("rd_timer_fe", rdata, 32'hffff_fffe);
      check("timer_ff", timer, 32'hffff_ffff);
      req(4'h0, 32'hbfaf_e000, 32'h0);
      check("rd_timer_ff", rdata, 32'hffff_ffff);
      check("timer_wrap", timer, 32'h0);
      req(4'h0, 32'hbfaf_e000, 32'h0);
      check("rd_timer_0", rdata, 32'h0);

      // Unmapped MMIO offset reads 0 and ignores writes
      req(4'h0, 32'h0000_0010, 32'h0);
      check("rd_ram_pre", rdata, 32'h5a5a_5a5a);
      req(4'hf, 32'hbfaf_0004, 32'h7777_7777);
      check("wr_unmapped", rdata, 32'h0);
      req(4'h0, 32'hbfaf_0004, 32'h0);
      check("rd_unmapped", rdata, 32'h0);

      // Reset mid-operation during a SCRATCH write stream
      en    = 1'b1;
      wen   = 4'hf;
      addr  = 32'hbfaf_f010;
      wdata = 32'h8765_4321;
      @(posedge clk);
      #1;
      check("stream_wr", rdata, 32'h8765_4321);
      wdata = 32'h9999_9999;
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_rdata", rdata, 32'h0);
      check("mid_rst_led", {16'h0, led}, 32'h0);
      check("mid_rst_timer", timer, 32'h0);
      @(posedge clk);
      #1;
      // A RAM write presented while reset is held is dropped too
      addr  = 32'h0000_0020;
      wdata = 32'h0;
      @(posedge clk);
      #1;
      en     = 1'b0;
      wen    = 4'h0;
      addr   = 32'h0;
      resetn = 1'b1;
      check("post_rst_timer", timer, 32'h0);
      check("post_rst_rdata", rdata, 32'h0);
      req(4'h0, 32'hbfaf_f010, 32'h0);
      check("rd_scratch_rst", rdata, 32'h0);
      req(4'h0, 32'h0000_0020, 32'h0);
      check("ram_kept_20", rdata, 32'hcafe_f00d);
      req(4'h0, 32'h0000_0010, 32'h0);
      check("ram_kept_10", rdata, 32'h5a5a_5a5a);
      check("led_after_rst", {16'h0, led}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
